// File: rtl/fx2_result_pipe_pkg.sv
// Shared constants for the FX2 result pipeline: default geometry, instruction IDs
// of the FX2 (rotate/shift) group and the decode helper that recognises them.
package fx2_result_pipe_pkg;

    localparam int FX2_LATENCY     = 4;
    localparam int FX2_KILL_STAGES = 2;
    localparam int ADDR_W_DEF      = 7;
    localparam int ID_W            = 7;
    localparam int DATA_W          = 128;

    // FX2 instruction IDs (rotate / shift family).
    localparam logic [ID_W-1:0] INSTR_ID_ROT   = 7'd32;
    localparam logic [ID_W-1:0] INSTR_ID_ROTH  = 7'd33;
    localparam logic [ID_W-1:0] INSTR_ID_ROTI  = 7'd34;
    localparam logic [ID_W-1:0] INSTR_ID_ROTHI = 7'd35;
    localparam logic [ID_W-1:0] INSTR_ID_SHL   = 7'd36;
    localparam logic [ID_W-1:0] INSTR_ID_SHLH  = 7'd37;
    localparam logic [ID_W-1:0] INSTR_ID_SHLI  = 7'd38;
    localparam logic [ID_W-1:0] INSTR_ID_SHLHI = 7'd39;

    // True when the ID belongs to the FX2 group; anything else may not write rt.
    function automatic logic is_fx2_id(input logic [ID_W-1:0] id);
        return id inside {INSTR_ID_ROT, INSTR_ID_ROTH, INSTR_ID_ROTI, INSTR_ID_ROTHI,
                          INSTR_ID_SHL, INSTR_ID_SHLH, INSTR_ID_SHLI, INSTR_ID_SHLHI};
    endfunction

endpackage

// File: rtl/fx2_result_pipe_if.sv
// Issue / hazard-check / writeback bundle of the FX2 result pipeline.
// Optional forwarding taps exist only when FX2_FWD_EN is defined.
interface fx2_result_pipe_if
    import fx2_result_pipe_pkg::*;
#(
    parameter int LATENCY = FX2_LATENCY,
    parameter int ADDR_W  = ADDR_W_DEF
);
    logic                 in_valid;
    logic [ID_W-1:0]      in_instr_id;
    logic [ADDR_W-1:0]    in_rt_addr;
    logic                 in_reg_wr;
    logic [DATA_W-1:0]    in_result;
    logic                 flush;
    logic [ADDR_W-1:0]    chk_addr_a;
    logic [ADDR_W-1:0]    chk_addr_b;
    logic [ADDR_W-1:0]    chk_addr_c;
    logic                 chk_hit_a;
    logic                 chk_hit_b;
    logic                 chk_hit_c;
    logic                 wb_valid;
    logic                 wb_reg_wr;
    logic [ADDR_W-1:0]    wb_rt_addr;
    logic [DATA_W-1:0]    wb_data;
`ifdef FX2_FWD_EN
    // Stage k occupies bit/slice k-1 (stage 1 in the lowest-index slice).
    logic [LATENCY-1:0]        fwd_valid;
    logic [LATENCY*ADDR_W-1:0] fwd_rt_addr;
    logic [LATENCY*DATA_W-1:0] fwd_data;
`endif

    // Issue side: drives instructions and operand addresses.
    modport master (
        output in_valid, in_instr_id, in_rt_addr, in_reg_wr, in_result, flush,
        output chk_addr_a, chk_addr_b, chk_addr_c,
        input  chk_hit_a, chk_hit_b, chk_hit_c,
        input  wb_valid, wb_reg_wr, wb_rt_addr, wb_data
`ifdef FX2_FWD_EN
        , input fwd_valid, fwd_rt_addr, fwd_data
`endif
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_instr_id, in_rt_addr, in_reg_wr, in_result, flush,
        input  chk_addr_a, chk_addr_b, chk_addr_c,
        output chk_hit_a, chk_hit_b, chk_hit_c,
        output wb_valid, wb_reg_wr, wb_rt_addr, wb_data
`ifdef FX2_FWD_EN
        , output fwd_valid, fwd_rt_addr, fwd_data
`endif
    );

endinterface

// File: rtl/fx2_result_pipe_stage.sv
// fx2_pipe_stage: one result-pipeline register stage. Kill empties the stage
// exactly like reset, so killed slots look identical to bubbles.
module fx2_pipe_stage
    import fx2_result_pipe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              valid_d,
    input  logic              reg_wr_d,
    input  logic [ADDR_W-1:0] rt_addr_d,
    input  logic [ID_W-1:0]   instr_id_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic              reg_wr_q,
    output logic [ADDR_W-1:0] rt_addr_q,
    output logic [ID_W-1:0]   instr_id_q,
    output logic [DATA_W-1:0] data_q
);

    // Stage register: clear on reset or kill, otherwise load the previous stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
        if (rst || kill) begin
            valid_q    <= 1'b0;
            reg_wr_q   <= 1'b0;
            rt_addr_q  <= '0;
            instr_id_q <= '0;
            data_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            reg_wr_q   <= reg_wr_d;
            rt_addr_q  <= rt_addr_d;
            instr_id_q <= instr_id_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: rtl/fx2_result_pipe.sv
// fx2_result_pipe: LATENCY-deep staging of FX2 ALU results to register-file writeback,
// with flush of the uncommitted stages and a 3-operand RAW hazard check.
// Optional feature macro: FX2_FWD_EN (per-stage forwarding taps; hazard check narrows
// to the uncommitted stages because later stages can be forwarded).
module fx2_result_pipe
    import fx2_result_pipe_pkg::*;
#(
    parameter int LATENCY     = FX2_LATENCY,
    parameter int KILL_STAGES = FX2_KILL_STAGES,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    fx2_result_pipe_if.slave    bus
);

`ifdef FX2_FWD_EN
    localparam int HAZ_LAST = KILL_STAGES;
`else
    localparam int HAZ_LAST = LATENCY - 1;
`endif

    // Stage k inputs (_d) and outputs (_q), k = 1..LATENCY.
    logic              valid_d    [1:LATENCY];
    logic              reg_wr_d   [1:LATENCY];
    logic [ADDR_W-1:0] rt_addr_d  [1:LATENCY];
    logic [ID_W-1:0]   instr_id_d [1:LATENCY];
    logic [DATA_W-1:0] data_d     [1:LATENCY];
    logic              valid_q    [1:LATENCY];
    logic              reg_wr_q   [1:LATENCY];
    logic [ADDR_W-1:0] rt_addr_q  [1:LATENCY];
    logic [ID_W-1:0]   instr_id_q [1:LATENCY];
    logic [DATA_W-1:0] data_q     [1:LATENCY];

    // Capture qualification: bubbles carry all-zero fields; only FX2 IDs may write rt.
    logic              cap_valid;
    logic              cap_reg_wr;
    logic [ADDR_W-1:0] cap_rt_addr;
    logic [ID_W-1:0]   cap_instr_id;
    logic [DATA_W-1:0] cap_data;

    assign cap_valid    = bus.in_valid;
    assign cap_reg_wr   = bus.in_valid & bus.in_reg_wr & is_fx2_id(bus.in_instr_id);
    assign cap_rt_addr  = bus.in_valid ? bus.in_rt_addr  : '0;
    assign cap_instr_id = bus.in_valid ? bus.in_instr_id : '0;
    assign cap_data     = bus.in_valid ? bus.in_result   : '0;

    for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
        if (k == 1) begin : g_first
            assign valid_d[k]    = cap_valid;
            assign reg_wr_d[k]   = cap_reg_wr;
            assign rt_addr_d[k]  = cap_rt_addr;
            assign instr_id_d[k] = cap_instr_id;
            assign data_d[k]     = cap_data;
        end else begin : g_chain
            assign valid_d[k]    = valid_q[k-1];
            assign reg_wr_d[k]   = reg_wr_q[k-1];
            assign rt_addr_d[k]  = rt_addr_q[k-1];
            assign instr_id_d[k] = instr_id_q[k-1];
            assign data_d[k]     = data_q[k-1];
        end

        fx2_pipe_stage #(.ADDR_W(ADDR_W)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .kill       (bus.flush && (k <= KILL_STAGES)),
            .valid_d    (valid_d[k]),
            .reg_wr_d   (reg_wr_d[k]),
            .rt_addr_d  (rt_addr_d[k]),
            .instr_id_d (instr_id_d[k]),
            .data_d     (data_d[k]),
            .valid_q    (valid_q[k]),
            .reg_wr_q   (reg_wr_q[k]),
            .rt_addr_q  (rt_addr_q[k]),
            .instr_id_q (instr_id_q[k]),
            .data_q     (data_q[k])
        );

`ifdef FX2_FWD_EN
        assign bus.fwd_valid[k-1]                   = valid_q[k];
        assign bus.fwd_rt_addr[(k-1)*ADDR_W +: ADDR_W] = rt_addr_q[k];
        assign bus.fwd_data[(k-1)*DATA_W +: DATA_W]    = data_q[k];
`endif
    end

    // Writeback is the last stage. The write enable is re-qualified against the carried
    // opcode so a non-FX2 result can never reach the register file.
    assign bus.wb_valid   = valid_q[LATENCY];
    assign bus.wb_reg_wr  = valid_q[LATENCY] & reg_wr_q[LATENCY] & is_fx2_id(instr_id_q[LATENCY]);
    assign bus.wb_rt_addr = rt_addr_q[LATENCY];
    assign bus.wb_data    = data_q[LATENCY];

    logic hit_a, hit_b, hit_c;

    // RAW hazard: OR of address matches over in-flight writing stages 1..HAZ_LAST.
    always_comb begin
        // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
        hit_a = 1'b0;
        hit_b = 1'b0;
        hit_c = 1'b0;
        for (int k = 1; k <= HAZ_LAST; k++) begin
            if (valid_q[k] && reg_wr_q[k]) begin
                if (rt_addr_q[k] == bus.chk_addr_a) hit_a = 1'b1;
                if (rt_addr_q[k] == bus.chk_addr_b) hit_b = 1'b1;
                if (rt_addr_q[k] == bus.chk_addr_c) hit_c = 1'b1;
            end
        end
    end

    assign bus.chk_hit_a = hit_a;
    assign bus.chk_hit_b = hit_b;
    assign bus.chk_hit_c = hit_c;

endmodule
